// File: rtl/stack_alu_pkg.sv
// Shared opcodes, response status codes and FSM state type for the stack ALU sequencer.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_UNDERFLOW = 2'b01;
  localparam logic [1:0] ST_FULL      = 2'b10;
  localparam logic [1:0] ST_ILLEGAL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_RESP
  } seq_state_e;

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Command and response valid/ready channels between a host and the stack ALU sequencer.
interface stack_alu_sequencer_if #(
  parameter int N = 32
);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_opcode;
  logic [N-1:0] cmd_data;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_ovf;
  logic [1:0]   res_status;

  modport master (
    output cmd_valid, cmd_opcode, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_ovf, res_status
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_ovf, res_status
  );

endinterface

// File: rtl/stack_depth_tracker.sv
// Mirror of the ALU stack depth; provides push/pop legality flags for the sequencer.
module stack_depth_tracker
  import stack_alu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         upd,
  input  logic                         inc,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         can_push,
  output logic                         can_pop1,
  output logic                         can_pop2
);

  localparam int DW = $clog2(DEPTH+1);

  logic [DW-1:0] depth_q, depth_d;

  assign can_push = (depth_q < DW'(DEPTH));
  assign can_pop1 = (depth_q != '0);
  assign can_pop2 = (depth_q > DW'(1));
  assign depth    = depth_q;

  // Guards keep the counter saturated even if the strobe arrives on an illegal edge case.
  always_comb begin
    depth_d = depth_q;
    if (upd) begin
      if (inc && can_push) begin
        depth_d = depth_q + DW'(1);
      end else if (!inc && can_pop1) begin
        depth_d = depth_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/stack_alu_sequencer.sv
// Initiator front end for STACK_BASED_ALU: one instruction in flight, NOP settle cycle, depth mirror.
// Optional sticky overflow flag with clear input is enabled by defining STACK_SEQ_STICKY_OVF_EN.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  stack_alu_sequencer_if.slave         bus,
  output logic [2:0]                   alu_opcode,
  output logic [N-1:0]                 alu_data,
  input  logic [N-1:0]                 alu_result,
  input  logic                         alu_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   depth
`ifdef STACK_SEQ_STICKY_OVF_EN
  ,
  output logic                         ovf_sticky,
  input  logic                         ovf_clear
`endif
);

  seq_state_e   state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [2:0]   alu_opcode_q, alu_opcode_d;
  logic [N-1:0] alu_data_q, alu_data_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         res_valid_q, res_valid_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic         res_ovf_q, res_ovf_d;
  logic [1:0]   res_status_q, res_status_d;

  logic         accept;
  logic         issue;
  logic [1:0]   early_status;
  logic         depth_upd;
  logic         can_push, can_pop1, can_pop2;

  stack_depth_tracker #(
    .DEPTH (DEPTH)
  ) u_depth (
    .clock    (clock),
    .reset    (reset),
    .upd      (depth_upd),
    .inc      (op_q == OP_PUSH),
    .depth    (depth),
    .can_push (can_push),
    .can_pop1 (can_pop1),
    .can_pop2 (can_pop2)
  );

  assign accept    = bus.cmd_valid && cmd_ready_q;
  assign depth_upd = (state_q == S_SETTLE);

  // Decide at acceptance whether the instruction reaches the ALU or is answered directly.
  always_comb begin
    issue        = 1'b0;
    early_status = ST_OK;
    unique case (bus.cmd_opcode)
      OP_NOP:          early_status = ST_OK;
      OP_ADD, OP_MUL: begin
        issue        = can_pop2;
        early_status = ST_UNDERFLOW;
      end
      OP_PUSH: begin
        issue        = can_push;
        early_status = ST_FULL;
      end
      OP_POP: begin
        issue        = can_pop1;
        early_status = ST_UNDERFLOW;
      end
      default:         early_status = ST_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    alu_opcode_d = OP_NOP;
    alu_data_d   = '0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_ovf_d    = res_ovf_q;
    res_status_d = res_status_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = bus.cmd_opcode;
          if (issue) begin
            state_d      = S_ISSUE;
            alu_opcode_d = bus.cmd_opcode;
            alu_data_d   = (bus.cmd_opcode == OP_PUSH) ? bus.cmd_data : '0;
          end else begin
            state_d      = S_RESP;
            res_valid_d  = 1'b1;
            res_data_d   = '0;
            res_ovf_d    = 1'b0;
            res_status_d = early_status;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_SETTLE;
      end
      // ALU output has settled by the end of this cycle; PUSH carries no result.
      S_SETTLE: begin
        state_d      = S_RESP;
        res_valid_d  = 1'b1;
        res_status_d = ST_OK;
        if (op_q == OP_PUSH) begin
          res_data_d = '0;
          res_ovf_d  = 1'b0;
        end else begin
          res_data_d = alu_result;
          res_ovf_d  = alu_overflow;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      alu_opcode_q <= OP_NOP;
      alu_data_q   <= '0;
      cmd_ready_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_ovf_q    <= 1'b0;
      res_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      alu_opcode_q <= alu_opcode_d;
      alu_data_q   <= alu_data_d;
      cmd_ready_q  <= cmd_ready_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_ovf_q    <= res_ovf_d;
      res_status_q <= res_status_d;
    end
  end

  assign alu_opcode     = alu_opcode_q;
  assign alu_data       = alu_data_q;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.res_status = res_status_q;

`ifdef STACK_SEQ_STICKY_OVF_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // A set in the same cycle as a clear wins.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (ovf_clear) begin
      ovf_sticky_d = 1'b0;
    end
    if ((state_q == S_SETTLE) && ((op_q == OP_ADD) || (op_q == OP_MUL)) && alu_overflow) begin
      ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
Initiator-side front end for the stack-based ALU. It accepts instruction words over a valid/ready handshake and drives the ALU's opcode/data port one instruction at a time, inserting the required NOP settle cycle. It mirrors the ALU stack depth to block underflow and overflow, captures the ALU result and overflow flag, and returns a status-tagged response over a second valid/ready handshake. It sits between a host/controller and STACK_BASED_ALU.

Parameters:
N, 32, data width of operands and results (matches the ALU data width)
DEPTH, 16, ALU stack depth mirrored by the internal depth counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  instruction word valid
cmd_ready  output  1  sequencer can accept an instruction
cmd_opcode  input  3  000 NOP, 100 ADD, 101 MUL, 110 PUSH, 111 POP; other codes are illegal
cmd_data  input  N  signed operand, PUSH only
alu_opcode  output  3  drives the ALU opcode input
alu_data  output  N  drives the ALU input_data
alu_result  input  N  ALU output_data
alu_overflow  input  1  ALU overflow output
res_valid  output  1  response valid
res_ready  input  1  response accepted
res_data  output  N  captured ALU result; 0 for PUSH, NOP and error responses
res_ovf  output  1  captured ALU overflow flag
res_status  output  2  00 OK, 01 UNDERFLOW, 10 FULL, 11 ILLEGAL
depth  output  $clog2(DEPTH+1)  mirrored stack depth

Behaviour:
- Reset (reset low, asynchronous): state IDLE, depth 0, alu_opcode 000, alu_data 0, res_valid 0, res_data 0, res_ovf 0, res_status 00, cmd_ready 1.
- FSM states: IDLE, ISSUE, SETTLE, RESP.
- cmd_ready is 1 only in IDLE. A handshake occurs when cmd_valid and cmd_ready are both 1 on a rising edge; the sequencer latches the opcode and data.
- IDLE to ISSUE on an accepted legal, non-rejected ADD/MUL/PUSH/POP.
- IDLE to RESP directly for:
  - NOP: status OK.
  - Illegal opcode: status ILLEGAL.
  - Rejected operation: the ALU is never driven.
- Rejection rules:
  - PUSH when depth == DEPTH: status FULL.
  - POP when depth == 0: status UNDERFLOW.
  - ADD/MUL when depth < 2: status UNDERFLOW.
- ISSUE (exactly 1 cycle): alu_opcode is the latched opcode; alu_data is the latched data for PUSH, else 0. Next state is SETTLE.
- SETTLE (exactly 1 cycle): alu_opcode 000. At the end of this cycle, res_data is captured from alu_result and res_ovf from alu_overflow (ADD/MUL/POP only). depth is updated: PUSH +1, POP −1, ADD/MUL −1. Next state is RESP.
- RESP: res_valid 1 and response fields held stable until res_ready is 1. Then res_valid drops and the state returns to IDLE.
- Latency: handshake at edge t. alu_opcode is valid during cycle t+1. res_valid asserts in cycle t+3. An error or NOP response asserts res_valid in cycle t+1.
- Throughput: at most one instruction in flight. No new command is accepted while a response is pending.
- alu_opcode is 000 in every state except ISSUE.
- Reset mid-operation returns to IDLE and depth 0 without completing the response. The ALU must be reset in the same domain so the two depths stay consistent.
- ADD/MUL width: the sequencer does not recompute arithmetic. res_ovf is exactly the ALU flag sampled at the end of SETTLE.

Optional Feature:
STACK_SEQ_STICKY_OVF_EN
- Defined: adds output ovf_sticky (1 bit) and input ovf_clear (1 bit).
  - ovf_sticky sets when an ADD/MUL response with res_ovf = 1 is captured.
  - It clears only on reset or when ovf_clear is 1 at a rising edge.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists. Behaviour is otherwise identical.

Decomposition:
- Shared package stack_alu_pkg holds:
  - Opcode localparams OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP.
  - Status codes ST_OK, ST_UNDERFLOW, ST_FULL, ST_ILLEGAL.
  - The FSM state enum.
- One natural sub-module, stack_depth_tracker: a depth counter with can_push/can_pop1/can_pop2 flags and an update strobe.

Test Plan:
- PUSH 100000, then PUSH 12345, then ADD → ADD response res_data 112345, res_ovf 0, status OK, depth 1; each PUSH response has status OK.
- After the previous case, MUL with depth 1 → status UNDERFLOW, alu_opcode never leaves 000, depth stays 1.
- PUSH 1000000, then PUSH 3000000, then MUL → res_ovf 1, status OK. With STACK_SEQ_STICKY_OVF_EN defined, ovf_sticky is 1 until ovf_clear is pulsed.
- POP from depth 0 → UNDERFLOW. Sixteen PUSHes then a 17th PUSH → 17th gets FULL, depth 16. Opcode 011 → ILLEGAL.
- Hold res_ready 0 for 5 cycles after a response → res_valid and res_data stable, cmd_ready stays 0.
- Assert reset low during SETTLE → all outputs at reset values immediately, without waiting for a clock edge; depth 0, no response emitted.
